// File: rtl/pipe_pkg.sv
// Shared constants for the Y86-64 PIPE control slice: icodes, status codes, FSM encoding.
package pipe_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] R_NONE = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pipe_state_e;

  // Reserved status encodings (0, 5-7) deliberately do not count as exceptions.
  function automatic logic is_exc(input logic [2:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by synchronous rst.
module pipe_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_control.sv
// PIPE hazard control: stall/bubble generation, RUN/HALTED FSM, hazard performance counters.
// Counters exist only when PIPE_PERF_CNT_EN is defined; otherwise they read as zero.
//
// state     | meaning
// ST_RUN    | pipeline advancing, hazard controls active
// ST_HALTED | non-AOK status reached writeback, core frozen until rst
module pipe_control
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [2:0]       halt_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  pipe_state_e state_q;
  logic [2:0]  halt_stat_q;
  logic        lu, rt, mp, run;

  assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
              (E_dstM != R_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign rt  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mp  = (E_icode == I_JXX) && !e_Cnd;
  assign run = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      halt_stat_q <= S_AOK;
    end else if (run && is_exc(W_stat)) begin
      state_q     <= ST_HALTED;
      halt_stat_q <= W_stat;
    end
  end

  // Load/use wins over ret: D must hold the consumer, so it is never bubbled at the same time.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b1;
    if (run) begin
      F_stall  = lu | rt;
      D_stall  = lu;
      D_bubble = mp | (rt & ~lu);
      E_bubble = mp | lu;
      M_bubble = is_exc(m_stat) | is_exc(W_stat);
      W_stall  = is_exc(W_stat);
    end
  end

  assign halted    = (state_q == ST_HALTED);
  assign halt_stat = halt_stat_q;

`ifdef PIPE_PERF_CNT_EN
  pipe_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk), .rst (rst), .inc (run), .q (cycle_cnt)
  );
  pipe_sat_counter #(.W(CNT_W)) u_loaduse_cnt (
    .clk (clk), .rst (rst), .inc (run & lu), .q (loaduse_cnt)
  );
  pipe_sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk (clk), .rst (rst), .inc (run & mp), .q (mispred_cnt)
  );
  pipe_sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk (clk), .rst (rst), .inc (run & rt & ~lu), .q (ret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign loaduse_cnt = '0;
  assign mispred_cnt = '0;
  assign ret_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control: directed scenarios plus randomized traffic vs a behavioural model.
module tb_pipe_control;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat;

  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [2:0]  halt_stat;
  logic [31:0] cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt;

  logic s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_halted;
  logic [2:0] s_halt_stat;
  logic [3:0] s_cycle_cnt, s_loaduse_cnt, s_mispred_cnt, s_ret_cnt;

  pipe_control #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .halt_stat(halt_stat), .cycle_cnt(cycle_cnt),
    .loaduse_cnt(loaduse_cnt), .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
  );

  pipe_control #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(s_F_stall), .D_stall(s_D_stall),
    .D_bubble(s_D_bubble), .E_bubble(s_E_bubble), .M_bubble(s_M_bubble), .W_stall(s_W_stall),
    .halted(s_halted), .halt_stat(s_halt_stat), .cycle_cnt(s_cycle_cnt),
    .loaduse_cnt(s_loaduse_cnt), .mispred_cnt(s_mispred_cnt), .ret_cnt(s_ret_cnt)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Behavioural model state
  bit          m_halted = 1'b0;
  logic [2:0]  m_hstat  = 3'd1;
  int unsigned m_cyc = 0, m_lu = 0, m_mp = 0, m_rt = 0;

  logic [137:0] obs_main;
  logic [25:0]  obs_sat;
  assign obs_main = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted, halt_stat,
                     cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt};
  assign obs_sat  = {s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_halted,
                     s_halt_stat, s_cycle_cnt, s_loaduse_cnt, s_mispred_cnt, s_ret_cnt};

  function automatic bit f_exc(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
  endfunction

  function automatic bit f_lu();
    return ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  endfunction

  function automatic bit f_rt();
    return (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
  endfunction

  function automatic bit f_mp();
    return (E_icode == 4'h7) && !e_Cnd;
  endfunction

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  function automatic logic [5:0] exp_ctl();
    if (m_halted) return 6'b110111;
    return {f_lu() | f_rt(), f_lu(), f_mp() | (f_rt() & !f_lu()), f_mp() | f_lu(),
            f_exc(m_stat) | f_exc(W_stat), f_exc(W_stat)};
  endfunction

  function automatic int unsigned exp_cnt(input int unsigned v, input int unsigned lim);
    return PERF ? ((v > lim) ? lim : v) : 0;
  endfunction

  function automatic logic [137:0] exp_main();
    return {exp_ctl(), m_halted, m_hstat,
            32'(exp_cnt(m_cyc, 32'hFFFF_FFFF)), 32'(exp_cnt(m_lu, 32'hFFFF_FFFF)),
            32'(exp_cnt(m_mp, 32'hFFFF_FFFF)), 32'(exp_cnt(m_rt, 32'hFFFF_FFFF))};
  endfunction

  function automatic logic [25:0] exp_sat();
    return {exp_ctl(), m_halted, m_hstat,
            4'(exp_cnt(m_cyc, 15)), 4'(exp_cnt(m_lu, 15)),
            4'(exp_cnt(m_mp, 15)), 4'(exp_cnt(m_rt, 15))};
  endfunction

  // Advance the model by one rising edge using the inputs presented to it.
  task automatic model_edge();
    if (rst) begin
      m_halted = 1'b0;
      m_hstat  = 3'd1;
      m_cyc = 0; m_lu = 0; m_mp = 0; m_rt = 0;
    end else if (!m_halted) begin
      m_cyc++;
      if (f_lu()) m_lu++;
      if (f_mp()) m_mp++;
      if (f_rt() && !f_lu()) m_rt++;
      if (f_exc(W_stat)) begin
        m_halted = 1'b1;
        m_hstat  = W_stat;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] di, sa, sb, ei, ed, input logic ec,
                        input logic [3:0] mi, input logic [2:0] ms, ws);
    D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = ed;
    e_Cnd = ec; M_icode = mi; m_stat = ms; W_stat = ws;
  endtask

  task automatic set_nop();
    set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_nop();
    tick();
    tick();
    rst = 1'b0;
    #1;
    if ({halted, halt_stat} !== 4'b0_001) begin
      err_cnt++; $display("FAIL reset_state got=%b exp=%b", {halted, halt_stat}, 4'b0_001);
    end
    vec_cnt++;
    if ({cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt} !== 128'd0) begin
      err_cnt++; $display("FAIL reset_counters got=%h exp=0", {cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt});
    end
    vec_cnt++;
    if (obs_main !== exp_main()) begin
      err_cnt++; $display("FAIL reset_main got=%h exp=%h", obs_main, exp_main());
    end
    vec_cnt++;
  endtask

  task automatic test_loaduse();
    logic [31:0] c0;
    set_in(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1);
    #1;
    if ({F_stall, D_stall, E_bubble, D_bubble} !== 4'b1110) begin
      err_cnt++; $display("FAIL loaduse_ctl got=%b exp=%b", {F_stall, D_stall, E_bubble, D_bubble}, 4'b1110);
    end
    vec_cnt++;
    c0 = loaduse_cnt;
    tick();
    #1;
    if (loaduse_cnt !== c0 + 32'(PERF)) begin
      err_cnt++; $display("FAIL loaduse_cnt got=%0d exp=%0d", loaduse_cnt, c0 + 32'(PERF));
    end
    vec_cnt++;
    if (obs_main !== exp_main()) begin
      err_cnt++; $display("FAIL loaduse_main got=%h exp=%h", obs_main, exp_main());
    end
    vec_cnt++;
  endtask

  task automatic test_mispredict();
    logic [31:0] c0;
    set_in(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
    #1;
    if ({D_bubble, E_bubble, F_stall} !== 3'b110) begin
      err_cnt++; $display("FAIL mispred_ctl got=%b exp=%b", {D_bubble, E_bubble, F_stall}, 3'b110);
    end
    vec_cnt++;
    c0 = mispred_cnt;
    tick();
    #1;
    if (mispred_cnt !== c0 + 32'(PERF)) begin
      err_cnt++; $display("FAIL mispred_cnt got=%0d exp=%0d", mispred_cnt, c0 + 32'(PERF));
    end
    vec_cnt++;
    e_Cnd = 1'b1;
    #1;
    if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} !== 6'b0) begin
      err_cnt++; $display("FAIL taken_ctl got=%b exp=000000",
                          {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall});
    end
    vec_cnt++;
    tick();
  endtask

  task automatic test_ret_loaduse();
    logic [31:0] c0;
    set_in(4'h9, 4'hF, 4'h2, 4'h5, 4'h2, 1'b1, 4'h1, 3'd1, 3'd1);
    #1;
    if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin
      err_cnt++; $display("FAIL ret_lu_ctl got=%b exp=%b", {F_stall, D_stall, D_bubble, E_bubble}, 4'b1101);
    end
    vec_cnt++;
    c0 = ret_cnt;
    tick();
    #1;
    if (ret_cnt !== c0) begin
      err_cnt++; $display("FAIL ret_lu_cnt got=%0d exp=%0d", ret_cnt, c0);
    end
    vec_cnt++;
    set_in(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
    #1;
    if ({F_stall, D_stall, D_bubble} !== 3'b101) begin
      err_cnt++; $display("FAIL ret_only_ctl got=%b exp=101", {F_stall, D_stall, D_bubble});
    end
    vec_cnt++;
    tick();
    #1;
    if (ret_cnt !== c0 + 32'(PERF)) begin
      err_cnt++; $display("FAIL ret_only_cnt got=%0d exp=%0d", ret_cnt, c0 + 32'(PERF));
    end
    vec_cnt++;
  endtask

  task automatic test_exception();
    logic [127:0] frozen;
    set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1);
    #1;
    if ({M_bubble, W_stall, halted} !== 3'b100) begin
      err_cnt++; $display("FAIL mexc_ctl got=%b exp=100", {M_bubble, W_stall, halted});
    end
    vec_cnt++;
    tick();
    W_stat = 3'd4;
    #1;
    if ({W_stall, M_bubble, halted} !== 3'b110) begin
      err_cnt++; $display("FAIL wexc_ctl got=%b exp=110", {W_stall, M_bubble, halted});
    end
    vec_cnt++;
    tick();
    #1;
    if ({halted, halt_stat} !== 4'b1_100) begin
      err_cnt++; $display("FAIL halt_entry got=%b exp=1100", {halted, halt_stat});
    end
    vec_cnt++;
    if (obs_main !== exp_main()) begin
      err_cnt++; $display("FAIL halt_main got=%h exp=%h", obs_main, exp_main());
    end
    vec_cnt++;
    frozen = {cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt};
    for (int i = 0; i < 10; i++) begin
      set_in(4'($urandom_range(0, 11)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 11)), 4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 11)),
             3'($urandom), 3'($urandom));
      #1;
      if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} !== 6'b110111) begin
        err_cnt++; $display("FAIL halted_ctl got=%b exp=110111",
                            {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall});
      end
      vec_cnt++;
      tick();
    end
    #1;
    if ({cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt} !== frozen) begin
      err_cnt++; $display("FAIL halt_frozen got=%h exp=%h", {cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt}, frozen);
    end
    vec_cnt++;
  endtask

  task automatic test_reset_mid_halt();
    set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    if ({halted, halt_stat} !== 4'b0_001) begin
      err_cnt++; $display("FAIL rst_halt_state got=%b exp=0001", {halted, halt_stat});
    end
    vec_cnt++;
    if ({cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt} !== 128'd0) begin
      err_cnt++; $display("FAIL rst_halt_cnt got=%h exp=0", {cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt});
    end
    vec_cnt++;
    if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} !== 6'b000011) begin
      err_cnt++; $display("FAIL rst_halt_ctl got=%b exp=000011",
                          {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall});
    end
    vec_cnt++;
    set_nop();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_in(4'($urandom_range(0, 11)), ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 11)), ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
             1'($urandom), 4'($urandom_range(0, 11)),
             ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd1,
             ($urandom_range(0, 39) == 0) ? 3'($urandom) : 3'd1);
      #1;
      if (obs_main !== exp_main()) begin
        err_cnt++; $display("FAIL random_main[%0d] got=%h exp=%h", i, obs_main, exp_main());
      end
      vec_cnt++;
      if (obs_sat !== exp_sat()) begin
        err_cnt++; $display("FAIL random_sat[%0d] got=%h exp=%h", i, obs_sat, exp_sat());
      end
      vec_cnt++;
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    set_nop();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #1;
    if (s_cycle_cnt !== (PERF ? 4'd15 : 4'd0)) begin
      err_cnt++; $display("FAIL sat_cycle got=%0d exp=%0d", s_cycle_cnt, PERF ? 15 : 0);
    end
    vec_cnt++;
    if (cycle_cnt !== (PERF ? 32'd20 : 32'd0)) begin
      err_cnt++; $display("FAIL wide_cycle got=%0d exp=%0d", cycle_cnt, PERF ? 20 : 0);
    end
    vec_cnt++;
    tick();
    #1;
    if (obs_sat !== exp_sat()) begin
      err_cnt++; $display("FAIL sat_hold got=%h exp=%h", obs_sat, exp_sat());
    end
    vec_cnt++;
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_mispredict();
    test_ret_loaduse();
    test_exception();
    test_reset_mid_halt();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
